// File: rtl/amm_master_pkg.sv
// Shared types and defaults for the Avalon-MM command initiator.
// The watchdog is compiled in only when AMM_MASTER_TIMEOUT_EN is defined.
package amm_master_pkg;

  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_MAX_PENDING    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // The inflight counter must hold the value MAX_PENDING itself.
  function automatic int inflight_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/amm_master_if.sv
// Command, response and Avalon-MM signal bundle of amm_master.
// The master modport is the initiator's view; slave is the environment's view.
interface amm_master_if
  import amm_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_address_i;
  logic [DATA_W-1:0] cmd_writedata_i;

  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_readdata_o;
  logic              rsp_error_o;

  logic [ADDR_W-1:0] amm_address_o;
  logic [DATA_W-1:0] amm_writedata_o;
  logic              amm_read_o;
  logic              amm_write_o;
  logic [DATA_W-1:0] amm_readdata_i;
  logic              amm_readdatavalid_i;
  logic              amm_waitrequest_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_address_i, cmd_writedata_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_readdata_o, rsp_error_o,
    output amm_address_o, amm_writedata_o, amm_read_o, amm_write_o,
    input  amm_readdata_i, amm_readdatavalid_i, amm_waitrequest_i
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_address_i, cmd_writedata_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_readdata_o, rsp_error_o,
    input  amm_address_o, amm_writedata_o, amm_read_o, amm_write_o,
    output amm_readdata_i, amm_readdatavalid_i, amm_waitrequest_i
  );

endinterface

// File: rtl/amm_master_timeout.sv
// Watchdog counter: counts enabled cycles without bus progress and flags
// the cycle in which the LIMIT-th such cycle is reached.
module amm_master_timeout
  import amm_master_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int            CW   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_q;

  assign expire_o = enable_i && !clear_i && (count_q == LAST);

  // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (!enable_i || clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + ONE;
    end
  end

endmodule

// File: rtl/amm_master.sv
// Avalon-MM initiator: single-word reads/writes from a command stream with
// bounded pipelined reads; optional watchdog under AMM_MASTER_TIMEOUT_EN.
module amm_master
  import amm_master_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_PENDING    = DEF_MAX_PENDING,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic         clk_i,
  input logic         rst_n_i,
  amm_master_if.master bus
);

  localparam int            IW      = inflight_width(MAX_PENDING);
  localparam logic [IW-1:0] MAX_CNT = IW'(MAX_PENDING);
  localparam logic [IW-1:0] ONE     = IW'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              read_q;
  logic              write_q;
  logic [IW-1:0]     inflight_q;
  logic [IW-1:0]     inflight_d;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
`ifdef AMM_MASTER_TIMEOUT_EN
  logic              rsp_error_q;
`endif

  logic bus_accept;
  logic cmd_ready;
  logic cmd_accept;
  logic rd_inc;
  logic rd_dec;
  logic timeout_expire;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    bus_accept = (read_q || write_q) && !bus.amm_waitrequest_i;
    cmd_ready  = (state_q != ST_FLUSH) && !timeout_expire &&
                 (state_q == ST_IDLE || !bus.amm_waitrequest_i) &&
                 (bus.cmd_write_i || (inflight_q < MAX_CNT) || bus.amm_readdatavalid_i);
    cmd_accept = bus.cmd_valid_i && cmd_ready;
    rd_inc     = cmd_accept && !bus.cmd_write_i;
    // Beats with nothing outstanding, or arriving during a flush, are dropped.
    rd_dec     = bus.amm_readdatavalid_i && (inflight_q != '0) && (state_q != ST_FLUSH);

    inflight_d = inflight_q;
    if (rd_inc && !rd_dec) begin
      inflight_d = inflight_q + ONE;
    end else if (!rd_inc && rd_dec) begin
      inflight_d = inflight_q - ONE;
    end
    if (state_q == ST_FLUSH && inflight_q != '0) begin
      inflight_d = inflight_q - ONE;
    end
  end

`ifdef AMM_MASTER_TIMEOUT_EN
  amm_master_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .enable_i ((state_q == ST_BUSY || inflight_q != '0) && state_q != ST_FLUSH),
    .clear_i  (bus_accept || bus.amm_readdatavalid_i),
    .expire_o (timeout_expire)
  );
  assign bus.rsp_error_o = rsp_error_q;
`else
  assign timeout_expire  = 1'b0;
  assign bus.rsp_error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      inflight_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef AMM_MASTER_TIMEOUT_EN
      rsp_error_q <= 1'b0;
`endif
    end else begin
      inflight_q  <= inflight_d;
      rsp_valid_q <= rd_dec;
      rsp_data_q  <= rd_dec ? bus.amm_readdata_i : '0;
`ifdef AMM_MASTER_TIMEOUT_EN
      rsp_error_q <= 1'b0;
`endif
      if (timeout_expire) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
        state_q <= ST_FLUSH;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_BUSY: begin
            // A new command while the current one completes keeps the strobe up.
            if (cmd_accept) begin
              addr_q  <= bus.cmd_address_i;
              wdata_q <= bus.cmd_writedata_i;
              read_q  <= !bus.cmd_write_i;
              write_q <= bus.cmd_write_i;
              state_q <= ST_BUSY;
            end else if (bus_accept) begin
              read_q  <= 1'b0;
              write_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          ST_FLUSH: begin
            if (inflight_q != '0) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
`ifdef AMM_MASTER_TIMEOUT_EN
              rsp_error_q <= 1'b1;
`endif
            end
            if (inflight_q <= ONE) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready_o     = cmd_ready;
  assign bus.amm_address_o   = addr_q;
  assign bus.amm_writedata_o = wdata_q;
  assign bus.amm_read_o      = read_q;
  assign bus.amm_write_o     = write_q;
  assign bus.rsp_valid_o     = rsp_valid_q;
  assign bus.rsp_readdata_o  = rsp_data_q;

endmodule

// File: tb/tb_amm_master.sv
// Self-checking bench for amm_master: behavioural responder plus a
// memory-image reference model of expected read responses.
module tb_amm_master;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MAXP = 4;
  localparam int TMO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amm_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  amm_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .MAX_PENDING    (MAXP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } beat_t;

  logic [31:0] smem    [256];
  logic [31:0] ref_mem [256];
  beat_t       pend_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] rsp_q[$];
  int          rsp_cyc_q[$];
  int          rd_acc_cyc_q[$];
  int          rdv_cyc_q[$];
  int          acc_q[$];

  // Responder configuration and observations.
  int       ws_fixed = 0;
  bit       ws_rand  = 1'b0;
  int       ws_max   = 0;
  int       rd_lat   = 1;
  bit       hang     = 1'b0;
  bit       stray    = 1'b0;
  int       wait_left = 0;
  bit       in_txn   = 1'b0;
  bit       holding  = 1'b0;
  logic [7:0]  hold_a;
  logic [31:0] hold_d;
  int       wr_cyc = 0, wr_rdy_lo = 0, overlap = 0, unstable = 0;

  function automatic logic [31:0] init_val(input int a);
    return 32'h5A000000 + 32'(a) * 32'h00010203;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Avalon responder: decides waitrequest/readdatavalid mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_if.amm_waitrequest_i   = 1'b0;
      bus_if.amm_readdatavalid_i = 1'b0;
      pend_q.delete();
      in_txn  = 1'b0;
      holding = 1'b0;
    end else begin
      bus_if.amm_readdatavalid_i = 1'b0;
      bus_if.amm_readdata_i      = $urandom;
      if (stray) begin
        bus_if.amm_readdatavalid_i = 1'b1;
        stray = 1'b0;
      end else if (!hang && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        beat_t b;
        b = pend_q.pop_front();
        bus_if.amm_readdatavalid_i = 1'b1;
        bus_if.amm_readdata_i      = b.data;
        rdv_cyc_q.push_back(cyc);
      end
      if (bus_if.amm_read_o && bus_if.amm_write_o) overlap++;
      if (bus_if.amm_write_o) wr_cyc++;
      bus_if.amm_waitrequest_i = 1'b0;
      if (bus_if.amm_read_o || bus_if.amm_write_o) begin
        if (holding && (bus_if.amm_address_o != hold_a ||
                        (bus_if.amm_write_o && bus_if.amm_writedata_o != hold_d)))
          unstable++;
        if (!in_txn) begin
          in_txn    = 1'b1;
          wait_left = ws_rand ? int'($urandom_range(0, ws_max)) : ws_fixed;
        end
        if (wait_left > 0) begin
          bus_if.amm_waitrequest_i = 1'b1;
          wait_left--;
          holding = 1'b1;
          hold_a  = bus_if.amm_address_o;
          hold_d  = bus_if.amm_writedata_o;
        end else begin
          in_txn  = 1'b0;
          holding = 1'b0;
          if (bus_if.amm_write_o) begin
            smem[bus_if.amm_address_o] = bus_if.amm_writedata_o;
          end else begin
            pend_q.push_back('{smem[bus_if.amm_address_o], cyc + rd_lat});
            rd_acc_cyc_q.push_back(cyc);
          end
        end
      end
    end
  end

  // Response / ready monitor, sampled well after the responder settles.
  always @(negedge clk) begin
    #3;
    if (bus_if.amm_write_o && !bus_if.cmd_ready_o) wr_rdy_lo++;
    if (bus_if.rsp_valid_o) begin
      rsp_q.push_back({bus_if.rsp_error_o, bus_if.rsp_readdata_o});
      rsp_cyc_q.push_back(cyc);
    end
  end

  task automatic send(input logic w, input int a, input logic [31:0] d);
    int n = 0;
    @(negedge clk); #1;
    bus_if.cmd_valid_i     = 1'b1;
    bus_if.cmd_write_i     = w;
    bus_if.cmd_address_i   = a[7:0];
    bus_if.cmd_writedata_i = d;
    #1;
    while (!bus_if.cmd_ready_o && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 300) check("cmd_accept_timeout", 64'(n), 64'd0);
    acc_q.push_back(cyc);
    if (w) ref_mem[a] = d;
    else   exp_q.push_back({1'b0, ref_mem[a]});
  endtask

  task automatic idle();
    @(negedge clk); #1;
    bus_if.cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend_q.size() > 0 || bus_if.amm_read_o || bus_if.amm_write_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", 64'(n), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_rsp(input string tag);
    check({tag, "_rsp_count"}, 64'(rsp_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rsp_q.size(); i++)
      check({tag, "_rsp"}, 64'(rsp_q[i]), 64'(exp_q[i]));
    rsp_q.delete();
    exp_q.delete();
    rsp_cyc_q.delete();
  endtask

  initial begin
    int lat_meas;
    for (int a = 0; a < 256; a++) begin
      smem[a]    = init_val(a);
      ref_mem[a] = init_val(a);
    end
    bus_if.cmd_valid_i         = 1'b0;
    bus_if.cmd_write_i         = 1'b0;
    bus_if.cmd_address_i       = '0;
    bus_if.cmd_writedata_i     = '0;
    bus_if.amm_readdata_i      = '0;
    bus_if.amm_readdatavalid_i = 1'b0;
    bus_if.amm_waitrequest_i   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_amm_read",  64'(bus_if.amm_read_o),      64'd0);
    check("rst_amm_write", 64'(bus_if.amm_write_o),     64'd0);
    check("rst_amm_addr",  64'(bus_if.amm_address_o),   64'd0);
    check("rst_amm_wdata", 64'(bus_if.amm_writedata_o), 64'd0);
    check("rst_rsp_valid", 64'(bus_if.rsp_valid_o),     64'd0);
    check("rst_rsp_data",  64'(bus_if.rsp_readdata_o),  64'd0);
    check("rst_rsp_error", 64'(bus_if.rsp_error_o),     64'd0);
    check("rst_cmd_ready", 64'(bus_if.cmd_ready_o),     64'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait write then read, readdatavalid one cycle after acceptance
    wr_cyc = 0;
    rd_acc_cyc_q.delete();
    send(1'b1, 3, 32'h12345678);
    send(1'b0, 3, 32'h0);
    idle();
    drain();
    check("p1_write_cycles", 64'(wr_cyc), 64'd1);
    lat_meas = (rsp_cyc_q.size() > 0 && rd_acc_cyc_q.size() > 0) ? rsp_cyc_q[0] - rd_acc_cyc_q[0] : -1;
    check("p1_rsp_latency", 64'(lat_meas), 64'd2);
    check("p1_rdata", 64'((rsp_q.size() > 0) ? rsp_q[0] : 33'h1_FFFFFFFF), {31'd0, 1'b0, 32'h12345678});
    compare_rsp("p1");

    // Write held by 5 wait states
    ws_fixed = 5; wr_cyc = 0; wr_rdy_lo = 0; unstable = 0;
    send(1'b1, 8'h40, $urandom);
    idle();
    drain();
    check("p2_write_cycles", 64'(wr_cyc),    64'd6);
    check("p2_ready_low",    64'(wr_rdy_lo), 64'd5);
    check("p2_stable",       64'(unstable),  64'd0);

    // Six back-to-back reads against a 10-cycle read latency
    ws_fixed = 0; rd_lat = 10;
    acc_q.delete(); rdv_cyc_q.delete();
    for (int i = 0; i < 6; i++) send(1'b0, 16 + i, 32'h0);
    idle();
    drain();
    check("p3_first4_b2b", 64'((acc_q.size() > 3) ? acc_q[3] - acc_q[0] : -1), 64'd3);
    check("p3_5th_at_rdv", 64'((acc_q.size() > 4) ? acc_q[4] : -1),
                           64'((rdv_cyc_q.size() > 0) ? rdv_cyc_q[0] : -2));
    check("p3_6th_at_rdv", 64'((acc_q.size() > 5) ? acc_q[5] : -1),
                           64'((rdv_cyc_q.size() > 1) ? rdv_cyc_q[1] : -2));
    compare_rsp("p3");

    // Randomized traffic with random wait states and several latencies
    ws_rand = 1'b1; ws_max = 3; overlap = 0; unstable = 0;
    for (int lat = 1; lat <= 7; lat += 3) begin
      rd_lat = lat;
      for (int i = 0; i < 25; i++) begin
        send(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
        if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      drain();
      compare_rsp("rand");
    end
    check("rand_no_overlap", 64'(overlap),  64'd0);
    check("rand_stable",     64'(unstable), 64'd0);
    ws_rand = 1'b0;

`ifdef AMM_MASTER_TIMEOUT_EN
    // Hung responder: two reads accepted, never answered
    begin
      int n = 0;
      int d;
      ws_fixed = 0; rd_lat = 1; hang = 1'b1;
      rd_acc_cyc_q.delete(); rsp_q.delete(); rsp_cyc_q.delete();
      send(1'b0, 1, 32'h0);
      send(1'b0, 2, 32'h0);
      idle();
      while (rsp_q.size() < 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      repeat (3) @(negedge clk);
      #4;
      check("wd_rsp_count", 64'(rsp_q.size()), 64'd2);
      check("wd_rsp0", 64'((rsp_q.size() > 0) ? rsp_q[0] : 33'h0), {31'd0, 1'b1, 32'h0});
      check("wd_rsp1", 64'((rsp_q.size() > 1) ? rsp_q[1] : 33'h0), {31'd0, 1'b1, 32'h0});
      d = (rsp_cyc_q.size() > 0 && rd_acc_cyc_q.size() > 1) ? rsp_cyc_q[0] - rd_acc_cyc_q[1] : -1;
      check("wd_delay_ok", 64'(d >= TMO + 1 && d <= TMO + 3), 64'd1);
      check("wd_consecutive", 64'((rsp_cyc_q.size() > 1) ? rsp_cyc_q[1] - rsp_cyc_q[0] : -1), 64'd1);
      check("wd_ready_after", 64'(bus_if.cmd_ready_o), 64'd1);
      pend_q.delete();
      hang = 1'b0;
      exp_q.delete(); rsp_q.delete(); rsp_cyc_q.delete();
    end
`endif

    // Reset while a read strobe is held by waitrequest
    ws_fixed = 20;
    rsp_q.delete();
    @(negedge clk); #1;
    bus_if.cmd_valid_i   = 1'b1;
    bus_if.cmd_write_i   = 1'b0;
    bus_if.cmd_address_i = 8'd9;
    #1;
    check("rst_mid_ready", 64'(bus_if.cmd_ready_o), 64'd1);
    @(negedge clk); #1;
    bus_if.cmd_valid_i = 1'b0;
    #1;
    check("rst_mid_read_held", 64'(bus_if.amm_read_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_read_cleared", 64'(bus_if.amm_read_o), 64'd0);
    check("rst_mid_ready_high",   64'(bus_if.cmd_ready_o), 64'd1);
    @(negedge clk);
    @(negedge clk); #1;
    rst_n    = 1'b1;
    ws_fixed = 0;
    stray    = 1'b1;
    repeat (5) @(negedge clk);
    #4;
    check("rst_stray_dropped", 64'(rsp_q.size()), 64'd0);
    rsp_q.delete(); rsp_cyc_q.delete(); exp_q.delete();
    rd_lat = 2;
    send(1'b0, 9, 32'h0);
    idle();
    drain();
    compare_rsp("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
